// File: rtl/risc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risc_pkg : shared types and constants for the instruction fetch stage      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package risc_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/risc_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risc_fetch_fifo : register-based FIFO of {pc, instr} fetch entries          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module risc_fetch_fifo
    import risc_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fetch_entry_t  entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risc_fetch_unit : single-outstanding instruction fetch with decode FIFO.    |
// | Define RISC_FETCH_PERF_EN to add the stall_cycles_o counter.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module risc_fetch_unit #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned INSTR_BYTES = risc_pkg::INSTR_BYTES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [risc_pkg::XLEN-1:0]  pc_i,
    output logic [2:0]                 pc_inc,
    output logic                       imem_req,
    output logic [risc_pkg::XLEN-1:0]  imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [risc_pkg::XLEN-1:0]  imem_rdata,
    input  logic                       flush_i,
    output logic [risc_pkg::XLEN-1:0]  instr_o,
    output logic [risc_pkg::XLEN-1:0]  instr_pc_o,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i
`ifdef RISC_FETCH_PERF_EN
    ,
    output logic [31:0]                stall_cycles_o
`endif
);

    import risc_pkg::*;

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [2:0]  INC = 3'(INSTR_BYTES);

    fetch_state_t    state_q;
    logic [XLEN-1:0] opc_q;
    logic            grant;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            unused_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A request is only raised with a free slot, so the eventual push never overflows.
    assign imem_req   = (state_q == FETCH) && !flush_i && !fifo_full;
    assign imem_addr  = pc_i;
    assign grant      = imem_req && imem_gnt;
    assign pc_inc     = grant ? INC : 3'd0;

    assign push       = (state_q == WAIT) && imem_rvalid && !flush_i;
    assign push_entry = '{pc: opc_q, instr: imem_rdata};
    assign pop        = !fifo_empty && instr_ready_i;

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign unused_count  = ^fifo_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            opc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (grant) begin
                        opc_q   <= pc_i;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    risc_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

`ifdef RISC_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (flush_i) begin
            stall_q <= '0;
        end else if (instr_ready_i && !instr_valid_o && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    // Stall counting is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_risc_fetch_unit : vector table, directed corner cases and random        |
// | traffic against a transaction-level model of the fetch stage.  Rev 1.0     |
// +----------------------------------------------------------------------------+
module tb_risc_fetch_unit;
    import risc_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [2:0]  TB_INC = 3'd4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] pc_i = '0;
    logic [2:0]      pc_inc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_valid_o;
    logic            instr_ready_i = 1'b0;
`ifdef RISC_FETCH_PERF_EN
    logic [31:0]     stall_cycles_o;
`endif

    always #5 clk = ~clk;

    risc_fetch_unit #(
        .DEPTH       (DEPTH),
        .INSTR_BYTES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .pc_inc        (pc_inc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .flush_i       (flush_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
`ifdef RISC_FETCH_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of buffered entries plus one outstanding transaction.
    fetch_entry_t    mq[$];
    bit              m_started;
    bit              m_inflight;
    bit              m_discard;
    logic [XLEN-1:0] m_opc;
    logic [31:0]     m_stall;
    logic [XLEN-1:0] tb_pc;

    logic            s_req;
    logic [2:0]      s_inc;
    logic [XLEN-1:0] s_addr;
    logic            s_valid;
    logic [XLEN-1:0] s_ipc;
    logic [XLEN-1:0] s_instr;
    logic [31:0]     s_stall;

    typedef struct {
        bit              gnt;
        bit              rv;
        bit              rdy;
        logic [XLEN-1:0] rdata;
        bit              e_req;
        logic [2:0]      e_inc;
        logic [XLEN-1:0] e_addr;
        bit              e_valid;
        logic [XLEN-1:0] e_ipc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        flush_i       = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        instr_ready_i = 1'b0;
        pc_i          = '0;
        reset         = 1'b0;
        #1;
        chk("rst_req",   64'(imem_req), 64'(0));
        chk("rst_inc",   64'(pc_inc), 64'(0));
        chk("rst_valid", 64'(instr_valid_o), 64'(0));
        chk("rst_instr", 64'(instr_o), 64'(0));
        chk("rst_ipc",   64'(instr_pc_o), 64'(0));
`ifdef RISC_FETCH_PERF_EN
        chk("rst_stall", 64'(stall_cycles_o), 64'(0));
`endif
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        mq.delete();
        m_started  = 1'b0;
        m_inflight = 1'b0;
        m_discard  = 1'b0;
        m_opc      = '0;
        m_stall    = '0;
        tb_pc      = '0;
    endtask

    // One clock cycle: drive at the falling edge, check before the rising edge, advance the model.
    task automatic step(input bit fl, input bit gnt, input bit rv, input bit rdy,
                        input logic [XLEN-1:0] rdata);
        bit           e_req;
        bit           e_valid;
        logic [2:0]   e_inc;
        bit           do_push;
        fetch_entry_t pushed;
        flush_i       = fl;
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        instr_ready_i = rdy;
        imem_rdata    = rdata;
        pc_i          = tb_pc;
        #1;
        e_valid = (mq.size() != 0);
        e_req   = m_started && !m_inflight && !fl && (mq.size() < int'(DEPTH));
        e_inc   = (e_req && gnt) ? TB_INC : 3'd0;
        s_req   = imem_req;
        s_inc   = pc_inc;
        s_addr  = imem_addr;
        s_valid = instr_valid_o;
        s_ipc   = instr_pc_o;
        s_instr = instr_o;
        chk("imem_req",  64'(s_req), 64'(e_req));
        chk("pc_inc",    64'(s_inc), 64'(e_inc));
        chk("imem_addr", 64'(s_addr), 64'(tb_pc));
        chk("valid",     64'(s_valid), 64'(e_valid));
        if (e_valid) begin
            chk("instr_o",    64'(s_instr), 64'(mq[0].instr));
            chk("instr_pc_o", 64'(s_ipc), 64'(mq[0].pc));
        end
`ifdef RISC_FETCH_PERF_EN
        s_stall = stall_cycles_o;
        chk("stall_cycles", 64'(s_stall), 64'(m_stall));
        if (fl) m_stall = '0;
        else if (rdy && !e_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`else
        s_stall = '0;
`endif
        do_push = 1'b0;
        pushed  = '{pc: m_opc, instr: rdata};
        if (m_inflight && rv) begin
            do_push    = !fl && !m_discard;
            m_inflight = 1'b0;
        end else if (m_inflight && fl) begin
            m_discard = 1'b1;
        end
        if (e_req && gnt) begin
            m_inflight = 1'b1;
            m_discard  = 1'b0;
            m_opc      = tb_pc;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (do_push) mq.push_back(pushed);
        end
        tb_pc     = tb_pc + 32'(e_inc);
        m_started = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Back-to-back fetch with gnt every cycle and rvalid one cycle later.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h13, 1'b0, 3'd0, 32'd0,  1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 3'd4, 32'd0,  1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 3'd0, 32'd4,  1'b0, 32'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 3'd4, 32'd4,  1'b1, 32'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 3'd0, 32'd8,  1'b0, 32'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 3'd4, 32'd8,  1'b1, 32'd4};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 3'd0, 32'd12, 1'b0, 32'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 3'd0, 32'd12, 1'b1, 32'd8};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].gnt, tbl[i].rv, tbl[i].rdy, tbl[i].rdata);
            chk("tbl_req",   64'(s_req), 64'(tbl[i].e_req));
            chk("tbl_inc",   64'(s_inc), 64'(tbl[i].e_inc));
            chk("tbl_addr",  64'(s_addr), 64'(tbl[i].e_addr));
            chk("tbl_valid", 64'(s_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_ipc",   64'(s_ipc), 64'(tbl[i].e_ipc));
                chk("tbl_instr", 64'(s_instr), 64'(32'h13));
            end
        end

        // Backpressure: two entries held, no request while full, resume at PC 8.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h13);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h13);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h13);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h13);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h17);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("bp_req_low", 64'(s_req), 64'(0));
            chk("bp_inc_zero", 64'(s_inc), 64'(0));
            chk("bp_head_pc", 64'(s_ipc), 64'(0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("bp_pop_req_low", 64'(s_req), 64'(0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("bp_resume_req", 64'(s_req), 64'(1));
        chk("bp_resume_addr", 64'(s_addr), 64'(8));
        chk("bp_head_pc4", 64'(s_ipc), 64'(4));
        chk("bp_head_instr", 64'(s_instr), 64'(32'h17));

        // Grant withheld for five cycles.
        do_reset();
        pc_i = 32'h100;
        tb_pc = 32'h100;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk("nognt_req", 64'(s_req), 64'(1));
            chk("nognt_addr", 64'(s_addr), 64'(32'h100));
            chk("nognt_valid", 64'(s_valid), 64'(0));
        end

        // Flush while waiting, response arrives three cycles later and is dropped.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("drain_req", 64'(s_req), 64'(0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("drain_valid", 64'(s_valid), 64'(0));
        chk("drain_resume_req", 64'(s_req), 64'(1));
        chk("drain_resume_addr", 64'(s_addr), 64'(4));

        // Flush coinciding with a pop and a response push.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hA1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hA2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("flushpp_valid", 64'(s_valid), 64'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("flushpp_valid2", 64'(s_valid), 64'(0));

`ifdef RISC_FETCH_PERF_EN
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("perf_seven", 64'(s_stall), 64'(7));
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("perf_flushed", 64'(s_stall), 64'(0));
`endif

        // Random traffic; the memory only answers while a request is outstanding.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0),
                 m_inflight && ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0),
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_fetch_unit.md
Name: risc_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Consumes the current PC and issues single-outstanding word reads to instruction memory.
- Buffers returned instructions, each tagged with its PC, in a small FIFO that feeds decode through a valid/ready handshake.
- Drives the PC's 3-bit increment input: 4 in the cycle a fetch is granted, 0 otherwise.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- DEPTH, 2, instruction FIFO entries (power of two, >=2).
- INSTR_BYTES, 4, increment driven on pc_inc per granted fetch (must fit 3 bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_i  in  XLEN  current PC from program counter.
- pc_inc  out  3  increment to program counter data input.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc_i).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  instruction word.
- flush_i  in  1  discard buffered/in-flight instructions.
- instr_o  out  XLEN  FIFO head instruction.
- instr_pc_o  out  XLEN  PC of instr_o.
- instr_valid_o  out  1  FIFO non-empty.
- instr_ready_i  in  1  decode accepts head.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, FIFO count=0, outstanding PC register=0.
  - Outputs: imem_req=0, pc_inc=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- States and transitions:
  - IDLE: outputs idle; next state FETCH unconditionally (one cycle after reset release).
  - FETCH: imem_req=1 iff flush_i=0 and count<DEPTH; imem_addr=pc_i.
    - On imem_req and imem_gnt: pc_inc=INSTR_BYTES (combinational, same cycle), pc_i captured into outstanding register, next state WAIT.
    - Otherwise pc_inc=0, stay in FETCH.
  - WAIT: imem_req=0, pc_inc=0.
    - On imem_rvalid and flush_i=0: push {outstanding PC, imem_rdata}, next state FETCH.
    - On imem_rvalid and flush_i=1: discard the data, next state FETCH.
    - Else if flush_i=1: next state DRAIN.
  - DRAIN: imem_req=0, pc_inc=0; on imem_rvalid discard the data, next state FETCH.
- Space rule: a request is issued only when count<DEPTH, so a push never overflows.
- FIFO:
  - instr_valid_o = (count!=0); head data comes from registers.
  - Pop when instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: gnt in cycle N, rvalid in N+1, instr_valid_o=1 in N+2. Peak throughput is one instruction per 2 cycles.
- flush_i:
  - Synchronous: count:=0 at the next edge, and any same-cycle push is dropped.
  - Forces imem_req=0 and pc_inc=0 that cycle.
  - The PC is not redirected; redirect is outside this block.
- pc_inc is never nonzero in any cycle without a grant.
- imem_rdata is ignored outside WAIT/DRAIN.
- Reset mid-WAIT: in-flight response is abandoned; the memory side must also be reset.

Optional Feature:
- Macro: RISC_FETCH_PERF_EN.
- Defined: adds output stall_cycles_o (32 bits).
  - Reset 0.
  - Increments each cycle instr_ready_i=1 and instr_valid_o=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by flush_i.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- risc_pkg:
  - fetch_state_t enum {IDLE, FETCH, WAIT, DRAIN}.
  - fetch_entry_t struct {pc, instr}.
  - XLEN and INSTR_BYTES constants.
- Sub-module risc_fetch_fifo:
  - Parameterised by DEPTH, storing fetch_entry_t.
  - push/pop/flush inputs; full/empty/count/head outputs.
- The FSM and handshake stay in risc_fetch_unit.

Test Plan:
- Reset release, pc_i=0, gnt=1 every cycle, rvalid one cycle after each gnt, imem_rdata=32'h0000_0013, ready=1 -> imem_req first high 1 cycle after release; pc_inc=4 only in grant cycles; instr_pc_o sequence 0,4,8; each instr_valid_o two cycles after its grant.
- ready=0, DEPTH=2, continuous gnt/rvalid -> two entries (PC 0,4) held; imem_req=0 while count=2; pc_inc stays 0; after ready=1 fetching resumes at PC 8.
- gnt=0 for 5 cycles -> imem_req held at 1 with addr unchanged; pc_inc=0; no push.
- flush_i pulsed in WAIT with rvalid 3 cycles later -> state DRAIN; response discarded; instr_valid_o=0; fetch resumes with the next request.
- flush_i in the same cycle as a pop and as an rvalid push -> count=0 next cycle; no entry survives.
- RISC_FETCH_PERF_EN defined, ready=1 with FIFO empty for 7 cycles -> stall_cycles_o=7; flush -> 0.
